// File: rtl/register_file_if.sv
// Operand bus between the control unit and the register file: read/write addresses,
// write strobe, result data, stall, the two read ports and the debug inspection port.
interface register_file_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ab;
    logic [ADDR_W-1:0] ad;
    logic              wr;
    logic [DATA_W-1:0] din;
    logic              stall;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output aa, ab, ad, wr, din, stall, dbg_addr,
        input  qa, qb, dbg_data
    );

    modport slave (
        input  aa, ab, ad, wr, din, stall, dbg_addr,
        output qa, qb, dbg_data
    );
endinterface

// File: rtl/register_file.sv
// Operand register file: two registered read ports with write-first bypass, one
// synchronous write port, optional hard-zero r0 and a combinational debug read port.
module register_file #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter bit ZERO_R0 = 1'b1
) (
    input logic            clk,
    input logic            rst,
    register_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_live;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;

    // A write to r0 is dropped entirely, so it must not feed the bypass either.
    assign wr_live = bus.wr && !(ZERO_R0 && (bus.ad == '0));

    assign val_a = (ZERO_R0 && (bus.aa == '0))       ? '0      :
                   (wr_live && (bus.ad == bus.aa))   ? bus.din :
                                                       mem[bus.aa];

    assign val_b = (ZERO_R0 && (bus.ab == '0))       ? '0      :
                   (wr_live && (bus.ad == bus.ab))   ? bus.din :
                                                       mem[bus.ab];

    assign bus.dbg_data = (ZERO_R0 && (bus.dbg_addr == '0)) ? '0 : mem[bus.dbg_addr];

    // NOTE: the array is built from flops rather than a RAM macro because every
    // register must clear asynchronously; a RAM cannot be reset like this.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (wr_live) begin
            mem[bus.ad] <= bus.din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.qa <= '0;
            bus.qb <= '0;
        end else if (!bus.stall) begin
            bus.qa <= val_a;
            bus.qb <= val_b;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios against fixed values,
// then randomized traffic checked against a behavioural register-file model.
module tb_register_file;
    localparam int DW = 8;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    register_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_mem [64];
    logic [DW-1:0] model_qa;
    logic [DW-1:0] model_qb;

    // What a read port sees for address x during the current cycle.
    function automatic logic [DW-1:0] ref_value(input logic [AW-1:0] x);
        if (x == 0) return '0;
        if (bus.wr && bus.ad == x) return bus.din;
        return model_mem[x];
    endfunction

    task automatic model_reset();
        foreach (model_mem[i]) model_mem[i] = '0;
        model_qa = '0;
        model_qb = '0;
    endtask

    task automatic drive(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                         input logic [AW-1:0] ad, input logic wr,
                         input logic [DW-1:0] din, input logic stall);
        bus.aa    = aa;
        bus.ab    = ab;
        bus.ad    = ad;
        bus.wr    = wr;
        bus.din   = din;
        bus.stall = stall;
    endtask

    // One clock edge; the model follows the same edge, outputs are sampled 1 ns later.
    task automatic tick();
        logic [DW-1:0] na;
        logic [DW-1:0] nb;
        na = ref_value(bus.aa);
        nb = ref_value(bus.ab);
        @(posedge clk);
        if (bus.wr && bus.ad != 0) model_mem[bus.ad] = bus.din;
        if (!bus.stall) begin
            model_qa = na;
            model_qb = nb;
        end
        #1;
    endtask

    task automatic test_reset();
        tests++; if (bus.qa !== 8'h00) begin fails++; $display("FAIL reset_qa: got %h expected 00", bus.qa); end
        tests++; if (bus.qb !== 8'h00) begin fails++; $display("FAIL reset_qb: got %h expected 00", bus.qb); end
        bus.dbg_addr = 6'd63; #1;
        tests++; if (bus.dbg_data !== 8'h00) begin fails++; $display("FAIL reset_dbg63: got %h expected 00", bus.dbg_data); end

        drive(6'd7, 6'd7, 6'd7, 1'b1, 8'h5A, 1'b0);
        tick();
        bus.wr = 1'b0;
        bus.dbg_addr = 6'd7; #1;
        tests++; if (bus.qa !== 8'h5A) begin fails++; $display("FAIL pre_reset_qa: got %h expected 5a", bus.qa); end
        tests++; if (bus.dbg_data !== 8'h5A) begin fails++; $display("FAIL pre_reset_dbg7: got %h expected 5a", bus.dbg_data); end

        // Assert reset while clk is high, well away from any edge.
        #1 rst = 1'b1;
        model_reset();
        #1;
        tests++; if (bus.qa !== 8'h00) begin fails++; $display("FAIL async_reset_qa: got %h expected 00", bus.qa); end
        tests++; if (bus.qb !== 8'h00) begin fails++; $display("FAIL async_reset_qb: got %h expected 00", bus.qb); end
        tests++; if (bus.dbg_data !== 8'h00) begin fails++; $display("FAIL async_reset_dbg7: got %h expected 00", bus.dbg_data); end

        // A write presented across an edge while reset is held must be discarded.
        drive(6'd9, 6'd9, 6'd9, 1'b1, 8'h99, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.wr = 1'b0;
        bus.dbg_addr = 6'd9; #1;
        tests++; if (bus.dbg_data !== 8'h00) begin fails++; $display("FAIL reset_write_dropped: got %h expected 00", bus.dbg_data); end
        tests++; if (bus.qa !== 8'h00) begin fails++; $display("FAIL reset_held_qa: got %h expected 00", bus.qa); end

        drive(6'd7, 6'd7, 6'd0, 1'b0, 8'h00, 1'b0);
        tick();
        tests++; if (bus.qa !== 8'h00) begin fails++; $display("FAIL post_reset_r7: got %h expected 00", bus.qa); end
    endtask

    task automatic test_basic();
        drive(6'd0, 6'd0, 6'd12, 1'b1, 8'h3C, 1'b0);
        tick();
        drive(6'd12, 6'd13, 6'd0, 1'b0, 8'h00, 1'b0);
        tick();
        tests++; if (bus.qa !== 8'h3C) begin fails++; $display("FAIL basic_qa: got %h expected 3c", bus.qa); end
        tests++; if (bus.qb !== 8'h00) begin fails++; $display("FAIL basic_qb: got %h expected 00", bus.qb); end
    endtask

    task automatic test_bypass();
        drive(6'd5, 6'd5, 6'd5, 1'b1, 8'hA7, 1'b0);
        tick();
        tests++; if (bus.qa !== 8'hA7) begin fails++; $display("FAIL bypass_qa: got %h expected a7", bus.qa); end
        tests++; if (bus.qb !== 8'hA7) begin fails++; $display("FAIL bypass_qb: got %h expected a7", bus.qb); end
        bus.wr = 1'b0;
        bus.dbg_addr = 6'd5; #1;
        tests++; if (bus.dbg_data !== 8'hA7) begin fails++; $display("FAIL bypass_dbg5: got %h expected a7", bus.dbg_data); end
    endtask

    task automatic test_r0();
        drive(6'd0, 6'd0, 6'd0, 1'b1, 8'hFF, 1'b0);
        tick();
        tests++; if (bus.qa !== 8'h00) begin fails++; $display("FAIL r0_bypass_qa: got %h expected 00", bus.qa); end
        tests++; if (bus.qb !== 8'h00) begin fails++; $display("FAIL r0_bypass_qb: got %h expected 00", bus.qb); end
        bus.wr = 1'b0;
        tick();
        tests++; if (bus.qa !== 8'h00) begin fails++; $display("FAIL r0_later_qa: got %h expected 00", bus.qa); end
        bus.dbg_addr = 6'd0; #1;
        tests++; if (bus.dbg_data !== 8'h00) begin fails++; $display("FAIL r0_dbg: got %h expected 00", bus.dbg_data); end
    endtask

    task automatic test_stall();
        drive(6'd0, 6'd0, 6'd1, 1'b1, 8'h11, 1'b0);
        tick();
        drive(6'd0, 6'd0, 6'd2, 1'b1, 8'h22, 1'b0);
        tick();
        drive(6'd1, 6'd1, 6'd0, 1'b0, 8'h00, 1'b0);
        tick();
        tests++; if (bus.qa !== 8'h11) begin fails++; $display("FAIL stall_setup_qa: got %h expected 11", bus.qa); end
        drive(6'd2, 6'd2, 6'd3, 1'b1, 8'h33, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++; if (bus.qa !== 8'h11) begin fails++; $display("FAIL stall_hold_qa[%0d]: got %h expected 11", c, bus.qa); end
            tests++; if (bus.qb !== 8'h11) begin fails++; $display("FAIL stall_hold_qb[%0d]: got %h expected 11", c, bus.qb); end
        end
        drive(6'd3, 6'd2, 6'd0, 1'b0, 8'h00, 1'b0);
        tick();
        tests++; if (bus.qa !== 8'h33) begin fails++; $display("FAIL stall_release_qa: got %h expected 33", bus.qa); end
        tests++; if (bus.qb !== 8'h22) begin fails++; $display("FAIL stall_release_qb: got %h expected 22", bus.qb); end
    endtask

    task automatic test_boundary();
        drive(6'd0, 6'd0, 6'd63, 1'b1, 8'h80, 1'b0);
        tick();
        drive(6'd0, 6'd0, 6'd62, 1'b1, 8'h01, 1'b0);
        tick();
        drive(6'd63, 6'd62, 6'd0, 1'b0, 8'h00, 1'b0);
        tick();
        tests++; if (bus.qa !== 8'h80) begin fails++; $display("FAIL boundary_r63: got %h expected 80", bus.qa); end
        tests++; if (bus.qb !== 8'h01) begin fails++; $display("FAIL boundary_r62: got %h expected 01", bus.qb); end
        drive(6'd0, 6'd1, 6'd0, 1'b0, 8'h00, 1'b0);
        tick();
        tests++; if (bus.qa !== 8'h00) begin fails++; $display("FAIL boundary_r0_alias: got %h expected 00", bus.qa); end
        tests++; if (bus.qb !== 8'h11) begin fails++; $display("FAIL boundary_r1_alias: got %h expected 11", bus.qb); end
        bus.dbg_addr = 6'd63; #1;
        tests++; if (bus.dbg_data !== 8'h80) begin fails++; $display("FAIL boundary_dbg63: got %h expected 80", bus.dbg_data); end
    endtask

    task automatic test_random();
        logic [AW-1:0] ad;
        logic [AW-1:0] aa;
        logic [AW-1:0] ab;
        for (int n = 0; n < 400; n++) begin
            // Draw addresses from a small pool half the time so collisions are frequent.
            ad = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 63));
            aa = ($urandom_range(0, 3) == 0) ? ad : (($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 63)));
            ab = ($urandom_range(0, 3) == 0) ? aa : (($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 63)));
            drive(aa, ab, ad, 1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 4) == 0));
            bus.dbg_addr = ($urandom_range(0, 1) == 0) ? ad : AW'($urandom_range(0, 63));
            tick();
            tests++; if (bus.qa !== model_qa) begin fails++; $display("FAIL random_qa[%0d]: got %h expected %h", n, bus.qa, model_qa); end
            tests++; if (bus.qb !== model_qb) begin fails++; $display("FAIL random_qb[%0d]: got %h expected %h", n, bus.qb, model_qb); end
            tests++; if (bus.dbg_data !== model_mem[bus.dbg_addr]) begin fails++; $display("FAIL random_dbg[%0d]: got %h expected %h", n, bus.dbg_data, model_mem[bus.dbg_addr]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive('0, '0, '0, 1'b0, '0, 1'b0);
        bus.dbg_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        test_reset();
        test_basic();
        test_bypass();
        test_r0();
        test_stall();
        test_boundary();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
